// File: rtl/epcs_seq.sv
`default_nettype none
// ============================================================================
//  Module      : epcs_seq
//  Description : EPCS flash command sequencer. Expands one high-level flash
//                operation (read byte, read status, program byte, sector
//                erase) into SPI engine transactions, inserting Write Enable
//                and status polling for program/erase.
//                Optional macro SEQ_TIMEOUT_EN: abort polling after
//                TIMEOUT_POLLS polls and flag seq_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module epcs_seq #(
    parameter logic [15:0] POLL_GAP      = 16'd64,
    parameter logic [23:0] TIMEOUT_POLLS = 24'd2000000
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        cmd_req,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [7:0]  seq_rdata,
    output logic        seq_err,
    output logic        spi_start,
    output logic [5:0]  spi_len,
    output logic [63:0] spi_wdata,
    input  logic        spi_busy,
    input  logic [7:0]  spi_rbyte
);

    localparam logic [1:0]  OP_READ   = 2'b00;
    localparam logic [1:0]  OP_PROG   = 2'b01;
    localparam logic [1:0]  OP_ERASE  = 2'b10;
    localparam logic [1:0]  OP_STAT   = 2'b11;

    localparam logic [63:0] WREN_WORD = {8'h06, 56'd0};
    localparam logic [63:0] RDSR_WORD = {8'h05, 56'd0};

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WREN      = 4'd1,
        S_WREN_WAIT = 4'd2,
        S_CMD       = 4'd3,
        S_CMD_WAIT  = 4'd4,
        S_GAP       = 4'd5,
        S_POLL      = 4'd6,
        S_POLL_WAIT = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        seen_q, seen_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [5:0]  len_q, len_d;
    logic [63:0] wd_q, wd_d;

`ifdef SEQ_TIMEOUT_EN
    logic [23:0] polls_q, polls_d;
    logic        err_q, err_d;
`else
    // Timeout limit has no function in this build.
    logic [23:0] unused_timeout_polls;
    assign unused_timeout_polls = TIMEOUT_POLLS;
`endif

    // SCLK count of the main command transaction for an operation.
    function automatic logic [5:0] cmd_len(input logic [1:0] op);
        case (op)
            OP_READ:  cmd_len = 6'd40;
            OP_PROG:  cmd_len = 6'd40;
            OP_ERASE: cmd_len = 6'd32;
            default:  cmd_len = 6'd16;
        endcase
    endfunction

    // MSB-first shift word of the main command transaction.
    function automatic logic [63:0] cmd_data(input logic [1:0]  op,
                                             input logic [23:0] a,
                                             input logic [7:0]  d);
        case (op)
            OP_READ:  cmd_data = {8'h03, a, 32'd0};
            OP_PROG:  cmd_data = {8'h02, a, d, 24'd0};
            OP_ERASE: cmd_data = {8'hD8, a, 32'd0};
            default:  cmd_data = RDSR_WORD;
        endcase
    endfunction

    logic w_wait_exit;
    logic w_gap_end;
    assign w_wait_exit = seen_q && !spi_busy;
    assign w_gap_end   = ({1'b0, gap_q} + 17'd1) >= {1'b0, POLL_GAP};

    // Next-state logic; transaction words are loaded on entry to each start state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        seen_d  = seen_q;
        gap_d   = gap_q;
        rdata_d = rdata_q;
        len_d   = len_q;
        wd_d    = wd_q;
`ifdef SEQ_TIMEOUT_EN
        polls_d = polls_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_req && !spi_busy) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    seen_d  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    polls_d = 24'd0;
                    err_d   = 1'b0;
`endif
                    if (cmd_op == OP_PROG || cmd_op == OP_ERASE) begin
                        state_d = S_WREN;
                        len_d   = 6'd8;
                        wd_d    = WREN_WORD;
                    end else begin
                        state_d = S_CMD;
                        len_d   = cmd_len(cmd_op);
                        wd_d    = cmd_data(cmd_op, cmd_addr, cmd_wdata);
                    end
                end
            end
            S_WREN: begin
                state_d = S_WREN_WAIT;
            end
            S_WREN_WAIT: begin
                if (spi_busy) begin
                    seen_d = 1'b1;
                end
                if (w_wait_exit) begin
                    seen_d  = 1'b0;
                    state_d = S_CMD;
                    len_d   = cmd_len(op_q);
                    wd_d    = cmd_data(op_q, addr_q, wdata_q);
                end
            end
            S_CMD: begin
                state_d = S_CMD_WAIT;
            end
            S_CMD_WAIT: begin
                if (spi_busy) begin
                    seen_d = 1'b1;
                end
                if (w_wait_exit) begin
                    seen_d = 1'b0;
                    if (op_q == OP_READ || op_q == OP_STAT) begin
                        rdata_d = spi_rbyte;
                        state_d = S_DONE;
                    end else begin
                        gap_d   = 16'd0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    state_d = S_POLL;
                    len_d   = 6'd16;
                    wd_d    = RDSR_WORD;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_POLL: begin
                state_d = S_POLL_WAIT;
`ifdef SEQ_TIMEOUT_EN
                if (polls_q != 24'hFFFFFF) begin
                    polls_d = polls_q + 24'd1;
                end
`endif
            end
            S_POLL_WAIT: begin
                if (spi_busy) begin
                    seen_d = 1'b1;
                end
                if (w_wait_exit) begin
                    seen_d  = 1'b0;
                    rdata_d = spi_rbyte;
                    if (spi_rbyte[0]) begin
                        gap_d   = 16'd0;
                        state_d = S_GAP;
`ifdef SEQ_TIMEOUT_EN
                        if (polls_q >= TIMEOUT_POLLS) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            addr_q  <= 24'd0;
            wdata_q <= 8'd0;
            seen_q  <= 1'b0;
            gap_q   <= 16'd0;
            rdata_q <= 8'd0;
            len_q   <= 6'd0;
            wd_q    <= 64'd0;
`ifdef SEQ_TIMEOUT_EN
            polls_q <= 24'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            seen_q  <= seen_d;
            gap_q   <= gap_d;
            rdata_q <= rdata_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
`ifdef SEQ_TIMEOUT_EN
            polls_q <= polls_d;
            err_q   <= err_d;
`endif
        end
    end

    // Start states last exactly one cycle, so spi_start can never be high twice in a row.
    assign spi_start = (state_q == S_WREN) || (state_q == S_CMD) || (state_q == S_POLL);
    assign seq_busy  = (state_q != S_IDLE);
    assign seq_done  = (state_q == S_DONE);
    assign seq_rdata = rdata_q;
    assign spi_len   = len_q;
    assign spi_wdata = wd_q;
`ifdef SEQ_TIMEOUT_EN
    assign seq_err   = err_q;
`else
    assign seq_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/epcs_seq.md
# epcs_seq

Command sequencer sitting between the CPU I/O decode and the SPI master engine that drives the EPCS configuration flash. It accepts one high-level flash operation at a time and expands it into the required SPI transactions: read byte, read status, program byte or sector erase. For program and erase it automatically issues Write Enable first, then polls the status register until the write-in-progress bit clears. This relieves software of the WREN/poll choreography.

## Interface
- POLL_GAP, 16'd64: idle clk50 cycles between consecutive status polls.
- TIMEOUT_POLLS, 24'd2000000: maximum status polls before an operation is aborted. Only used with SEQ_TIMEOUT_EN.

- clk50  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_req  in  1  operation request; sampled only in IDLE.
- cmd_op  in  2  00 read byte, 01 program byte, 10 sector erase, 11 read status.
- cmd_addr  in  24  flash byte/sector address, captured on accept.
- cmd_wdata  in  8  program data, captured on accept.
- seq_busy  out  1  high from the cycle after accept through the DONE cycle.
- seq_done  out  1  one-cycle completion pulse.
- seq_rdata  out  8  read byte or status byte; holds until the next completion.
- seq_err  out  1  timeout flag for the last operation; cleared on the next accept.
- spi_start  out  1  one-cycle start pulse to the SPI engine.
- spi_len  out  6  SCLK count for the transaction (engine clk_end).
- spi_wdata  out  64  MSB-first shift data (engine wr_data).
- spi_busy  in  1  engine busy.
- spi_rbyte  in  8  last 8 bits shifted in (engine rd_1byte).

## Operation
- States: IDLE, WREN, WREN_WAIT, CMD, CMD_WAIT, GAP, POLL, POLL_WAIT, DONE.
- IDLE: if cmd_req=1 and spi_busy=0, capture op/addr/wdata and clear seq_err. Go to WREN for program or erase; go to CMD for read or status.
- WREN: spi_len=8, spi_wdata={8'h06,56'd0}, pulse spi_start, then go to WREN_WAIT.
- CMD, per op:
  - Read: len 40, {8'h03,addr,32'd0}.
  - Status: len 16, {8'h05,56'd0}.
  - Program: len 40, {8'h02,addr,wdata,24'd0}.
  - Erase: len 32, {8'hD8,addr,32'd0}.
- *_WAIT states: set an internal seen flag when spi_busy=1. Exit when the flag is set and spi_busy=0.
- CMD_WAIT exit:
  - Read or status: latch seq_rdata<=spi_rbyte and go to DONE.
  - Program or erase: go to GAP.
- GAP: count POLL_GAP cycles, then go to POLL.
- POLL: len 16, {8'h05,56'd0}, pulse spi_start, then go to POLL_WAIT.
- POLL_WAIT exit: latch seq_rdata<=spi_rbyte. If bit0=1 (WIP), go to GAP; otherwise go to DONE.
- DONE: seq_done=1 for one cycle, then go to IDLE.
- spi_len and spi_wdata are held stable from the start pulse until the matching WAIT state exits.
- cmd_req outside IDLE is ignored. No queuing.

## Timing
- Reset: state IDLE, seen flag and counters 0. All outputs 0: seq_busy, seq_done, seq_rdata, seq_err, spi_start, spi_len, spi_wdata.
- spi_start is never high on two consecutive cycles, so the engine's edge detect always fires.
- spi_busy rises one cycle after spi_start. The seen flag prevents the WAIT state from exiting on the pre-rise low.
- spi_rbyte is valid on the first cycle spi_busy reads 0 after busy was seen. It is sampled on that cycle.
- Read/status latency: accept -> seq_done = 1 (CMD) + 1 (busy rise) + engine time + 2 cycles.
- Simultaneous cmd_req and seq_done: the request is not accepted that cycle. It can be accepted on the following IDLE cycle.
- Reset mid-operation returns to IDLE at once. Because the engine may still be shifting, IDLE waits for spi_busy=0 before accepting.
- Poll counter is 24-bit and saturates; it never wraps.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - Each POLL increments a poll counter.
  - If the counter reaches TIMEOUT_POLLS while WIP=1, set seq_err=1 and go to DONE.
  - seq_rdata holds the last status byte.
- SEQ_TIMEOUT_EN undefined:
  - No counter is built and seq_err is tied 0.
  - Polling continues until WIP=0.

## Test plan
- Read: op 00, addr 24'h012345, model returns 8'hA5. Required: one transaction, len 40, wdata 64'h0301234500000000; seq_rdata=8'hA5; single seq_done pulse.
- Status: op 11, model status 8'h02. Required: len 16, wdata 64'h0500000000000000; seq_rdata=8'h02.
- Program: op 01, addr 24'h000010, data 8'h3C, model WIP=1 for 3 polls. Required sequence: 06 (len 8), 02 000010 3C (len 40), then 4 polls with POLL_GAP-cycle gaps; seq_done with seq_rdata bit0=0.
- Erase: op 10, addr 24'h050000. Required: 06, then D8 050000 (len 32), polls; cmd_req pulses during busy are ignored.
- With SEQ_TIMEOUT_EN and TIMEOUT_POLLS=5, WIP stuck at 1. Required: exactly 5 polls, seq_err=1, seq_done pulse; next accept clears seq_err.
- Reset asserted during the erase CMD transaction. Required: outputs reset to 0; a new read is accepted only after spi_busy falls, and completes normally.
